uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, system clock in MHz.
REQ-002 SHALL have parameter TIMEOUT_US, default 1000, inter-byte timeout in microseconds.
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum payload bytes (range 1..255).
REQ-004 SHALL have port i_sys_clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-006 SHALL have port i_recv_en  input  1  byte-ready from the UART receiver.
REQ-007 SHALL have port i_recv_data  input  8  received byte, valid while i_recv_en high.
REQ-008 SHALL have port o_frame_valid  output  1  complete good frame held for the consumer.
REQ-009 SHALL have port i_frame_ack  input  1  consumer releases the held frame.
REQ-010 SHALL have port o_cmd  output  8  command byte of the held frame.
REQ-011 SHALL have port o_len  output  8  payload length of the held frame.
REQ-012 SHALL have port i_rd_addr  input  8  payload buffer read address.
REQ-013 SHALL have port o_rd_data  output  8  payload byte at i_rd_addr.
REQ-014 SHALL have port o_err  output  1  one-cycle error pulse.
REQ-015 SHALL have port o_err_code  output  2  01 checksum, 10 length, 11 timeout; held until the next error.
REQ-016 SHALL have port o_overrun  output  1  one-cycle pulse, byte dropped while a frame is held.

Function
REQ-017 SHALL accept a byte only on a rising edge of i_recv_en: i_recv_en=1 with the registered previous value 0. It SHALL sample i_recv_data in that same cycle.
REQ-018 SHALL parse frames in this order: 0x55, 0xAA, LEN, CMD, LEN payload bytes, CHK. CHK is the mod-256 sum of LEN, CMD and all payload bytes.
REQ-019 SHALL implement states IDLE, HDR2, LEN, CMD, PAYLOAD, CHK and HOLD.
REQ-020 In IDLE, an accepted 0x55 SHALL move the state to HDR2; any other byte SHALL be ignored.
REQ-021 In HDR2:
- 0xAA SHALL move the state to LEN.
- 0x55 SHALL keep the state in HDR2.
- Any other byte SHALL return the state to IDLE with no error.
REQ-022 In LEN, a value of 0 or greater than MAX_LEN SHALL pulse o_err with code 10 and return to IDLE; otherwise the state SHALL move to CMD.
REQ-023 In CMD, the byte SHALL be stored and the state SHALL move to PAYLOAD.
REQ-024 In PAYLOAD, each byte SHALL be written to the buffer at index 0..LEN-1. The state SHALL move to CHK after byte LEN-1.
REQ-025 In CHK, a matching checksum SHALL enter HOLD. A mismatch SHALL pulse o_err with code 01 and return to IDLE.
REQ-026 o_frame_valid SHALL assert in the cycle after the CHK byte is accepted.
REQ-027 While in HOLD, o_frame_valid, o_cmd, o_len and the buffer SHALL remain stable.
REQ-028 In HOLD, i_frame_ack=1 SHALL return the state to IDLE. o_frame_valid SHALL be 0 in the next cycle.
REQ-029 Any byte accepted in HOLD SHALL be dropped and SHALL pulse o_overrun the next cycle. This applies even when i_frame_ack is high in the same cycle.
REQ-030 In states HDR2 through CHK, TIMEOUT_US*CLK_FRE cycles with no accepted byte SHALL pulse o_err with code 11 and return to IDLE.
REQ-031 The timeout counter SHALL clear on every accepted byte and in IDLE and HOLD.
REQ-032 o_rd_data SHALL be registered, with 1-cycle latency from i_rd_addr. It SHALL return 0 for addresses at or above MAX_LEN.
REQ-033 o_err and o_overrun SHALL each be high for exactly one cycle per event.
REQ-034 A header-pair abort (REQ-021) SHALL raise no error.

Reset
REQ-035 While i_rst is high, the state SHALL be IDLE and all outputs SHALL be 0, including o_err_code.
REQ-036 While i_rst is high, the edge-detect register, checksum accumulator, byte counter and timeout counter SHALL be 0.
REQ-037 Buffer contents need not be cleared by reset.
REQ-038 Reset asserted mid-frame or in HOLD SHALL discard the frame; parsing SHALL restart at IDLE after release.

Verification
REQ-039 Bytes 55 AA 02 10 01 02 15 -> o_frame_valid=1 one cycle after 0x15, o_cmd=0x10, o_len=2, addr0 reads 0x01, addr1 reads 0x02; held until i_frame_ack, then low the next cycle.
REQ-040 Same frame with CHK=0x16 -> o_err one pulse, o_err_code=01, o_frame_valid stays 0.
REQ-041 Bytes 55 AA 00 and 55 AA 11 (MAX_LEN=16) -> o_err with code 10 for each; a following valid frame is accepted.
REQ-042 Bytes 55 55 AA 01 20 07 28 -> header resync; frame valid, o_cmd=0x20, o_len=1, addr0 reads 0x07.
REQ-043 Bytes 55 AA 03, then silence for TIMEOUT_US*CLK_FRE cycles -> o_err with code 11; a byte sent in HOLD -> o_overrun one pulse and the held data unchanged.
REQ-044 i_recv_en held high for 10 cycles -> exactly one byte accepted; i_rst pulsed during PAYLOAD -> all outputs 0 and no frame_valid for the partial frame.

Source files
------------

// File: rtl/uart_frame_parser.sv
// ============================================================================
// Module : uart_frame_parser
// Brief  : Parses 55 AA LEN CMD PAYLOAD CHK frames from a UART byte stream and
//          holds each good frame until the consumer acknowledges it.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_parser #(
  parameter int CLK_FRE    = 50,
  parameter int TIMEOUT_US = 1000,
  parameter int MAX_LEN    = 16
) (
  input  logic       i_sys_clk,
  input  logic       i_rst,
  input  logic       i_recv_en,
  input  logic [7:0] i_recv_data,
  output logic       o_frame_valid,
  input  logic       i_frame_ack,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  input  logic [7:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun
);

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_US * CLK_FRE - 1);

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR2    = 3'd1,
    LEN     = 3'd2,
    CMD     = 3'd3,
    PAYLOAD = 3'd4,
    CHK     = 3'd5,
    HOLD    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        en_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  len_q, len_d;
  logic [31:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  rd_q;
  logic        wr_en;
  logic        accept;
  logic        in_frame;

  logic [7:0] mem [MAX_LEN];

  assign accept   = i_recv_en & ~en_q;
  assign in_frame = (state_q != IDLE) && (state_q != HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    tmo_d   = tmo_q + 32'd1;
    err_d   = 1'b0;
    code_d  = code_q;
    ovr_d   = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (accept && i_recv_data == 8'h55) state_d = HDR2;
      end
      HDR2: begin
        if (accept) begin
          if (i_recv_data == 8'hAA)      state_d = LEN;
          else if (i_recv_data != 8'h55) state_d = IDLE;
        end
      end
      LEN: begin
        if (accept) begin
          if (i_recv_data == 8'd0 || i_recv_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = IDLE;
          end else begin
            len_d   = i_recv_data;
            sum_d   = i_recv_data;
            state_d = CMD;
          end
        end
      end
      CMD: begin
        if (accept) begin
          cmd_d   = i_recv_data;
          sum_d   = sum_q + i_recv_data;
          cnt_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          sum_d = sum_q + i_recv_data;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = CHK;
        end
      end
      CHK: begin
        if (accept) begin
          if (i_recv_data == sum_q) begin
            state_d = HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHK;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        tmo_d = '0;
        // A byte arriving while held is dropped even if the ack lands with it.
        if (accept)      ovr_d   = 1'b1;
        if (i_frame_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) tmo_d = '0;

    if (in_frame && !accept && tmo_q == TO_LAST) begin
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      ovr_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= i_recv_en;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
      rd_q    <= (i_rd_addr < MAX_LEN_B) ? mem[i_rd_addr[AW-1:0]] : 8'h00;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge i_sys_clk) begin
    if (wr_en) mem[cnt_q[AW-1:0]] <= i_recv_data;
  end

  assign o_frame_valid = (state_q == HOLD);
  assign o_cmd         = cmd_q;
  assign o_len         = len_q;
  assign o_rd_data     = rd_q;
  assign o_err         = err_q;
  assign o_err_code    = code_q;
  assign o_overrun     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
// ============================================================================
// Module : tb_uart_frame_parser
// Brief  : Directed self-checking bench for uart_frame_parser.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_frame_parser;

  localparam int CLK_FRE    = 1;
  localparam int TIMEOUT_US = 40;
  localparam int MAX_LEN    = 16;
  localparam int TO_CYC     = CLK_FRE * TIMEOUT_US;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       recv_en = 1'b0;
  logic [7:0] recv_data = 8'h00;
  logic       ack = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic       frame_valid, err, overrun;
  logic [7:0] cmd, len, rd_data;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail  = 0;

  uart_frame_parser #(
    .CLK_FRE   (CLK_FRE),
    .TIMEOUT_US(TIMEOUT_US),
    .MAX_LEN   (MAX_LEN)
  ) dut (
    .i_sys_clk    (clk),
    .i_rst        (rst),
    .i_recv_en    (recv_en),
    .i_recv_data  (recv_data),
    .o_frame_valid(frame_valid),
    .i_frame_ack  (ack),
    .o_cmd        (cmd),
    .o_len        (len),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_err        (err),
    .o_err_code   (err_code),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    recv_en   = 1'b1;
    recv_data = b;
    @(negedge clk);
    recv_en   = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [8], input int n);
    for (int i = 0; i < n; i++) send_byte(s[i]);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = addr;
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check(tag, frame_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, frame_valid, 0);
    check({tag, "_cmd"},   cmd, 0);
    check({tag, "_len"},   len, 0);
    check({tag, "_rd"},    rd_data, 0);
    check({tag, "_err"},   err, 0);
    check({tag, "_code"},  err_code, 0);
    check({tag, "_ovr"},   overrun, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Good frame 55 AA 02 10 01 02 15
    send_seq('{8'h55, 8'hAA, 8'h02, 8'h10, 8'h01, 8'h02, 8'h00, 8'h00}, 6);
    check("f1_valid_before_chk", frame_valid, 0);
    send_byte(8'h15);
    check("f1_valid", frame_valid, 1);
    check("f1_cmd", cmd, 8'h10);
    check("f1_len", len, 8'h02);
    read_chk("f1_addr0", 8'd0, 8'h01);
    read_chk("f1_addr1", 8'd1, 8'h02);
    read_chk("f1_addr16", 8'd16, 8'h00);
    repeat (5) @(negedge clk);
    check("f1_held", frame_valid, 1);
    do_ack("f1_ack");

    // Bad checksum
    send_seq('{8'h55, 8'hAA, 8'h02, 8'h10, 8'h01, 8'h02, 8'h16, 8'h00}, 7);
    check("chk_err", err, 1);
    check("chk_code", err_code, 2'b01);
    check("chk_valid", frame_valid, 0);
    @(negedge clk);
    check("chk_err_pulse", err, 0);

    // Length errors, then a good frame
    send_seq('{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check("len0_err", err, 1);
    check("len0_code", err_code, 2'b10);
    send_seq('{8'h55, 8'hAA, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check("len17_err", err, 1);
    check("len17_code", err_code, 2'b10);
    send_seq('{8'h55, 8'hAA, 8'h01, 8'h30, 8'h05, 8'h36, 8'h00, 8'h00}, 6);
    check("len_ok_valid", frame_valid, 1);
    check("len_ok_cmd", cmd, 8'h30);
    do_ack("len_ok_ack");

    // Header resync 55 55 AA ...
    send_seq('{8'h55, 8'h55, 8'hAA, 8'h01, 8'h20, 8'h07, 8'h28, 8'h00}, 7);
    check("rs_valid", frame_valid, 1);
    check("rs_cmd", cmd, 8'h20);
    check("rs_len", len, 8'h01);
    read_chk("rs_addr0", 8'd0, 8'h07);

    // Overrun in HOLD
    send_byte(8'h99);
    check("ovr_pulse", overrun, 1);
    check("ovr_valid", frame_valid, 1);
    @(negedge clk);
    check("ovr_pulse_end", overrun, 0);
    check("ovr_cmd", cmd, 8'h20);
    read_chk("ovr_addr0", 8'd0, 8'h07);

    // Overrun coincident with ack
    @(negedge clk);
    recv_en = 1'b1;
    recv_data = 8'h55;
    ack = 1'b1;
    @(negedge clk);
    recv_en = 1'b0;
    ack = 1'b0;
    check("ovr_ack_pulse", overrun, 1);
    check("ovr_ack_valid", frame_valid, 0);

    // Timeout after 55 AA 03
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < TO_CYC + 10 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (err) seen = 1'b1;
    end
    check("tmo_seen", seen, 1);
    check("tmo_cycles", n, TO_CYC);
    check("tmo_code", err_code, 2'b11);

    // recv_en held high: one payload byte only
    send_seq('{8'h55, 8'hAA, 8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    @(negedge clk);
    recv_en = 1'b1;
    recv_data = 8'h11;
    repeat (10) @(negedge clk);
    recv_en = 1'b0;
    send_byte(8'h22);
    send_byte(8'h75);
    check("hold_hi_valid", frame_valid, 1);
    read_chk("hold_hi_addr0", 8'd0, 8'h11);
    read_chk("hold_hi_addr1", 8'd1, 8'h22);
    do_ack("hold_hi_ack");

    // Reset during payload
    rd_addr = 8'd0;
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h50, 8'h01, 8'h00, 8'h00, 8'h00}, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    send_seq('{8'h02, 8'h03, 8'h59, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    @(negedge clk);
    check("midrst_no_valid", frame_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
